ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_ctrl.sv | 97 +++++++++
 tb/tb_ram_bist_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: BIST sequencer for a 16x4 RAM: write pattern, read/write-inverse march, descending inverse read.
// Optional macro BIST_ERR_CNT_EN adds Err_Cnt and runs every phase to completion despite mismatches.
module ram_bist_ctrl #(
   parameter logic [3:0] PATTERN   = 4'hA,
   parameter logic [3:0] LAST_ADDR = 4'd15
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Start,
   input  logic [3:0] Mem_Out,
   output logic [3:0] Data,
   output logic       RD,
   output logic       WR,
   output logic [3:0] Address,
   output logic       Busy,
   output logic       Done,
   output logic       Pass,
   output logic [3:0] Fail_Addr
`ifdef BIST_ERR_CNT_EN
   ,
   output logic [5:0] Err_Cnt
`endif
);
   typedef enum logic [2:0] {IDLE, W_PAT, R_PAT, W_INV, R_INV, FIN} state_t;
`ifdef BIST_ERR_CNT_EN
   localparam bit STOP_ON_ERR = 1'b0;
`else
   localparam bit STOP_ON_ERR = 1'b1;
`endif
   state_t     state, state_nx;
   logic [3:0] addr_nx;
   logic       err, mism, accept;
   assign accept = (state == IDLE || state == FIN) && Start;
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= IDLE;
         Address <= 4'd0;
      end else begin
         state   <= state_nx;
         Address <= addr_nx;
      end
   end
   // err latches the first mismatch so Fail_Addr keeps the earliest failing address
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         err       <= 1'b0;
         Fail_Addr <= 4'd0;
`ifdef BIST_ERR_CNT_EN
         Err_Cnt   <= 6'd0;
`endif
      end else if (accept) begin
         err       <= 1'b0;
         Fail_Addr <= 4'd0;
`ifdef BIST_ERR_CNT_EN
         Err_Cnt   <= 6'd0;
`endif
      end else if (mism) begin
         err       <= 1'b1;
         Fail_Addr <= err ? Fail_Addr : Address;
`ifdef BIST_ERR_CNT_EN
         Err_Cnt   <= Err_Cnt + 6'd1;
`endif
      end
   end
   always_comb begin
      state_nx = state;
      addr_nx  = Address;
      case (state)
         IDLE, FIN: if (Start) begin
            state_nx = W_PAT;
            addr_nx  = 4'd0;
         end
         W_PAT: if (Address == LAST_ADDR) begin
            state_nx = R_PAT;
            addr_nx  = 4'd0;
         end else addr_nx = Address + 4'd1;
         R_PAT: state_nx = (mism && STOP_ON_ERR) ? FIN : W_INV;
         W_INV: if (Address == LAST_ADDR) state_nx = R_INV;
         else begin
            state_nx = R_PAT;
            addr_nx  = Address + 4'd1;
         end
         R_INV: if ((mism && STOP_ON_ERR) || Address == 4'd0) state_nx = FIN;
         else addr_nx = Address - 4'd1;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      RD   = state == R_PAT || state == R_INV;
      WR   = state == W_PAT || state == W_INV;
      Data = state == W_PAT ? PATTERN : state == W_INV ? ~PATTERN : 4'd0;
      Busy = RD || WR;
      Done = state == FIN;
      Pass = Done && !err;
      mism = (state == R_PAT && Mem_Out != PATTERN) || (state == R_INV && Mem_Out != ~PATTERN);
   end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: drives the BIST against a behavioural 16x4 RAM with injectable stuck-at faults.
// A scoreboard queue holds the expected outcome of each run; a monitor checks RD/WR exclusivity and address order.
module tb_ram_bist_ctrl;
   logic       Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0;
   logic [3:0] Mem_Out, Data, Address, Fail_Addr;
   logic       RD, WR, Busy, Done, Pass;
`ifdef BIST_ERR_CNT_EN
   logic [5:0] Err_Cnt;
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif
   logic [3:0] mem [16];
   logic [3:0] and_m [16];
   logic [3:0] or_m [16];
   int tests = 0, fails = 0;
   typedef struct {logic pass; logic [3:0] fa; int cyc; int errs;} exp_t;
   exp_t q[$];

   ram_bist_ctrl dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Mem_Out(Mem_Out), .Data(Data),
      .RD(RD), .WR(WR), .Address(Address), .Busy(Busy), .Done(Done), .Pass(Pass),
      .Fail_Addr(Fail_Addr)
`ifdef BIST_ERR_CNT_EN
      , .Err_Cnt(Err_Cnt)
`endif
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) if (WR) mem[Address] <= Data;
   always_comb Mem_Out = (mem[Address] & and_m[Address]) | or_m[Address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // phase code: 1 pattern write, 2 inverse write, 3 read; consecutive reads only occur in R_INV
   int ph, prev_ph = 0;
   logic [3:0] prev_addr;
   always @(negedge Clk) begin
      if (!Rst_n) prev_ph = 0;
      else begin
         ph = WR ? (Data == 4'hA ? 1 : 2) : RD ? 3 : 0;
         chk("rd_wr_excl", {31'd0, RD && WR}, 32'd0);
         if (ph == 1 && prev_ph == 1) chk("wpat_asc", {28'd0, Address}, {28'd0, prev_addr + 4'd1});
         if (ph == 3 && prev_ph == 3) chk("rinv_desc", {28'd0, Address}, {28'd0, prev_addr - 4'd1});
         prev_ph   = ph;
         prev_addr = Address;
      end
   end

   task automatic clear_faults();
      for (int i = 0; i < 16; i++) begin
         and_m[i] = 4'hF;
         or_m[i]  = 4'h0;
      end
   endtask

   task automatic run(input string tag, input int extra_start);
      exp_t e;
      int cyc;
      @(negedge Clk) Start = 1'b1;
      @(posedge Clk) #1 Start = 1'b0;
      chk({tag, "_busy0"}, {31'd0, Busy}, 32'd1);
      chk({tag, "_done0"}, {31'd0, Done}, 32'd0);
      chk({tag, "_pass0"}, {31'd0, Pass}, 32'd0);
      cyc = 0;
      while (!Done && cyc < 200) begin
         Start = (cyc == extra_start);
         @(posedge Clk) #1;
         cyc++;
      end
      Start = 1'b0;
      e = q.pop_front();
      chk({tag, "_done"}, {31'd0, Done}, 32'd1);
      chk({tag, "_cycles"}, cyc, e.cyc);
      chk({tag, "_pass"}, {31'd0, Pass}, {31'd0, e.pass});
      chk({tag, "_fail_addr"}, {28'd0, Fail_Addr}, {28'd0, e.fa});
      chk({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
`ifdef BIST_ERR_CNT_EN
      chk({tag, "_err_cnt"}, {26'd0, Err_Cnt}, e.errs);
`endif
      repeat (3) @(posedge Clk);
      #1 chk({tag, "_done_hold"}, {31'd0, Done}, 32'd1);
   endtask

   initial begin
      int n;
      clear_faults();
      #1;
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_pass", {31'd0, Pass}, 32'd0);
      chk("rst_rdwr", {30'd0, RD, WR}, 32'd0);
      chk("rst_addr", {28'd0, Address}, 32'd0);
      chk("rst_data", {28'd0, Data}, 32'd0);
      chk("rst_fail_addr", {28'd0, Fail_Addr}, 32'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk) Rst_n = 1'b1;
      repeat (4) @(posedge Clk);
      #1 chk("idle_no_start", {31'd0, Busy}, 32'd0);

      q.push_back('{1'b1, 4'd0, 64, 0});
      run("healthy", -1);
      q.push_back('{1'b1, 4'd0, 64, 0});
      run("restart_busy_start", 10);

      and_m[5] = 4'b1110;
      q.push_back('{1'b0, 4'd5, CNT_ON ? 64 : 59, 1});
      run("a5_b0_sa0", -1);
      clear_faults();

      or_m[3] = 4'b0100;
      q.push_back('{1'b0, 4'd3, CNT_ON ? 64 : 23, 1});
      run("a3_b2_sa1", -1);
      clear_faults();

      q.push_back('{1'b1, 4'd0, 64, 0});
      run("healthy_again", -1);

      @(negedge Clk) Start = 1'b1;
      @(posedge Clk) #1 Start = 1'b0;
      n = 0;
      while (!(RD && Address == 4'd7) && n < 100) begin
         @(posedge Clk) #1;
         n++;
      end
      chk("reach_rpat7", {31'd0, RD && Address == 4'd7}, 32'd1);
      #2 Rst_n = 1'b0;
      #1;
      chk("mid_rst_rdwr", {30'd0, RD, WR}, 32'd0);
      chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
      chk("mid_rst_addr", {28'd0, Address}, 32'd0);
      @(negedge Clk) Rst_n = 1'b1;
      repeat (5) @(posedge Clk);
      #1 chk("post_rst_idle", {31'd0, Busy || Done}, 32'd0);

      q.push_back('{1'b1, 4'd0, 64, 0});
      run("after_rst", -1);
      chk("queue_empty", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
